// File: rtl/slice_packer.sv
// slice_packer: assembles a wide word from a stream of narrow slices.
// Each accepted slice lands at an auto-incrementing slot; slot 0 is the LSBs.
// Optional feature macro: SLICE_PACKER_FLUSH_EN (adds in_last / out_count so a
// word can be closed early, with unwritten upper slots reading as zero).
module slice_packer #(
    parameter  int SLICE_WIDTH      = 4,
    parameter  int SELECT_BUS_WIDTH = 3,
    localparam int WORD_WIDTH       = SLICE_WIDTH * (2 ** SELECT_BUS_WIDTH),
    localparam int IDX_WIDTH        = (SELECT_BUS_WIDTH > 0) ? SELECT_BUS_WIDTH : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SLICE_WIDTH-1:0]      in_slice,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WORD_WIDTH-1:0]       out_word,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef SLICE_PACKER_FLUSH_EN
    input  logic                        in_last,
    output logic [SELECT_BUS_WIDTH:0]   out_count,
`endif
    output logic [IDX_WIDTH-1:0]        fill_index
);

    localparam int NUM_SLICES  = 2 ** SELECT_BUS_WIDTH;
    localparam int COUNT_WIDTH = SELECT_BUS_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SLICES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]            r_state;
    logic [IDX_WIDTH-1:0]  r_fillIndex;
    logic [WORD_WIDTH-1:0] r_outWord;
    logic                  r_outValid;
`ifdef SLICE_PACKER_FLUSH_EN
    logic [COUNT_WIDTH-1:0] r_outCount;
`endif

    logic                  w_inReady;
    logic                  w_accept;
    logic                  w_close;
    logic [WORD_WIDTH-1:0] w_nextWord;

    // In HOLD a new slice can only enter when the consumer frees the word this cycle.
    assign w_inReady = rst_n && ((r_state == ST_FILL) || out_ready);
    assign w_accept  = in_valid && w_inReady;

`ifdef SLICE_PACKER_FLUSH_EN
    assign w_close = (r_fillIndex == LAST_IDX) || in_last;
`else
    assign w_close = (r_fillIndex == LAST_IDX);
`endif

    // Merge the incoming slice into the current word; on an early close, blank the slots above it.
    always_comb begin
        w_nextWord = r_outWord;
        for (int s = 0; s < NUM_SLICES; s++) begin
            if (s == int'(r_fillIndex)) begin
                w_nextWord[s*SLICE_WIDTH +: SLICE_WIDTH] = in_slice;
            end
`ifdef SLICE_PACKER_FLUSH_EN
            else if (in_last && (s > int'(r_fillIndex))) begin
                w_nextWord[s*SLICE_WIDTH +: SLICE_WIDTH] = '0;
            end
`endif
        end
    end

    // FILL/HOLD control: accept slices, close words, release them to the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_fillIndex <= '0;
            r_outWord   <= '0;
            r_outValid  <= 1'b0;
`ifdef SLICE_PACKER_FLUSH_EN
            r_outCount  <= '0;
`endif
        end else if (w_accept) begin
            r_outWord <= w_nextWord;
            if (w_close) begin
                r_state     <= ST_HOLD;
                r_fillIndex <= '0;
                r_outValid  <= 1'b1;
`ifdef SLICE_PACKER_FLUSH_EN
                r_outCount  <= COUNT_WIDTH'(int'(r_fillIndex) + 1);
`endif
            end else begin
                r_state     <= ST_FILL;
                r_fillIndex <= r_fillIndex + IDX_ONE;
                r_outValid  <= 1'b0;
            end
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_state    <= ST_FILL;
            r_outValid <= 1'b0;
        end
    end

    assign in_ready   = w_inReady;
    assign out_word   = r_outWord;
    assign out_valid  = r_outValid;
    assign fill_index = r_fillIndex;
`ifdef SLICE_PACKER_FLUSH_EN
    assign out_count  = r_outCount;
`endif

endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer: scoreboard bench for slice_packer (SELECT_BUS_WIDTH=2 and =0 instances).
// Exercises the SLICE_PACKER_FLUSH_EN scenario when that macro is defined.
module tb_slice_packer;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  count;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  inSlice;
    logic        inValid;
    logic        inReady;
    logic [15:0] outWord;
    logic        outValid;
    logic        outReady;
    logic [1:0]  fillIndex;
    logic        inLast;
    logic [2:0]  outCount;

    logic [3:0]  inSlice0;
    logic        inValid0;
    logic        inReady0;
    logic [3:0]  outWord0;
    logic        outValid0;
    logic        outReady0;
    logic [0:0]  fillIndex0;
    logic        inLast0;
    logic [0:0]  outCount0;

    exp_t        expQ[$];
    logic [3:0]  expQ0[$];

    int testsRun;
    int testsFailed;

    slice_packer #(.SLICE_WIDTH(4), .SELECT_BUS_WIDTH(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_slice   (inSlice),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .out_word   (outWord),
        .out_valid  (outValid),
        .out_ready  (outReady),
`ifdef SLICE_PACKER_FLUSH_EN
        .in_last    (inLast),
        .out_count  (outCount),
`endif
        .fill_index (fillIndex)
    );

    slice_packer #(.SLICE_WIDTH(4), .SELECT_BUS_WIDTH(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_slice   (inSlice0),
        .in_valid   (inValid0),
        .in_ready   (inReady0),
        .out_word   (outWord0),
        .out_valid  (outValid0),
        .out_ready  (outReady0),
`ifdef SLICE_PACKER_FLUSH_EN
        .in_last    (inLast0),
        .out_count  (outCount0),
`endif
        .fill_index (fillIndex0)
    );

`ifndef SLICE_PACKER_FLUSH_EN
    assign outCount  = 3'd0;
    assign outCount0 = 1'b0;
`endif

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one slice that must be accepted on the next rising edge.
    task automatic applyStimulus(input logic [3:0] slice, input logic last);
        inSlice = slice;
        inLast  = last;
        inValid = 1'b1;
        #1;
        checkOutput("in_ready before accept", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inLast = 1'b0;
    endtask

    task automatic idle(input int cycles);
        inValid = 1'b0;
        inLast  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the 4-slot packer: every handed-off word is popped and compared.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected word: got 0x%0h, expected none", outWord);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_word", 32'(outWord), 32'(e.word));
`ifdef SLICE_PACKER_FLUSH_EN
                checkOutput("out_count", 32'(outCount), 32'(e.count));
`endif
            end
        end
    end

    // Monitor for the one-slot packer.
    always @(negedge clk) begin
        if (rst_n && outValid0 && outReady0) begin
            if (expQ0.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected word0: got 0x%0h, expected none", outWord0);
            end else begin
                logic [3:0] e0;
                e0 = expQ0.pop_front();
                checkOutput("out_word0", 32'(outWord0), 32'(e0));
`ifdef SLICE_PACKER_FLUSH_EN
                checkOutput("out_count0", 32'(outCount0), 32'd1);
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n     = 1'b0;
        inSlice   = 4'h0;
        inValid   = 1'b0;
        inLast    = 1'b0;
        outReady  = 1'b0;
        inSlice0  = 4'h0;
        inValid0  = 1'b0;
        inLast0   = 1'b0;
        outReady0 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset fill_index", 32'(fillIndex), 32'd0);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset out_word", 32'(outWord), 32'd0);
        checkOutput("reset in_ready", 32'(inReady), 32'd0);
        checkOutput("reset out_count", 32'(outCount), 32'd0);
        checkOutput("reset out_valid0", 32'(outValid0), 32'd0);
        rst_n = 1'b1;

        // Basic fill: valid for exactly one cycle after the last slice.
        outReady = 1'b1;
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        expQ.push_back('{word: 16'h4321, count: 3'd4});
        applyStimulus(4'h4, 1'b0);
        inValid = 1'b0;
        checkOutput("basic out_valid after last", 32'(outValid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("basic out_valid next cycle", 32'(outValid), 32'd0);
        idle(2);

        // Backpressure: word held while the consumer stalls.
        outReady = 1'b0;
        applyStimulus(4'hA, 1'b0);
        applyStimulus(4'hB, 1'b0);
        applyStimulus(4'hC, 1'b0);
        expQ.push_back('{word: 16'hDCBA, count: 3'd4});
        applyStimulus(4'hD, 1'b0);
        inSlice = 4'hE;
        inValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("hold out_word", 32'(outWord), 32'hDCBA);
            checkOutput("hold in_ready", 32'(inReady), 32'd0);
            checkOutput("hold fill_index", 32'(fillIndex), 32'd0);
            checkOutput("hold out_valid", 32'(outValid), 32'd1);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        applyStimulus(4'h7, 1'b0);
        checkOutput("release fill_index", 32'(fillIndex), 32'd1);
        checkOutput("release out_valid", 32'(outValid), 32'd0);
        applyStimulus(4'h8, 1'b0);
        applyStimulus(4'h9, 1'b0);
        expQ.push_back('{word: 16'hA987, count: 3'd4});
        applyStimulus(4'hA, 1'b0);
        idle(2);

        // Streaming: sixteen back-to-back slices with no bubbles.
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 3) begin
                logic [15:0] w;
                w = {4'(i), 4'(i - 1), 4'(i - 2), 4'(i - 3)};
                expQ.push_back('{word: w, count: 3'd4});
            end
            applyStimulus(4'(i), 1'b0);
        end
        idle(2);

        // Reset mid-word discards the partial contents.
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset fill_index", 32'(fillIndex), 32'd0);
        checkOutput("midreset out_valid", 32'(outValid), 32'd0);
        rst_n = 1'b1;
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        expQ.push_back('{word: 16'h4321, count: 3'd4});
        applyStimulus(4'h4, 1'b0);
        idle(2);

`ifdef SLICE_PACKER_FLUSH_EN
        // Early close: upper slots blank, count reflects slices written.
        applyStimulus(4'h1, 1'b0);
        expQ.push_back('{word: 16'h0021, count: 3'd2});
        applyStimulus(4'h2, 1'b1);
        checkOutput("flush fill_index", 32'(fillIndex), 32'd0);
        checkOutput("flush out_valid", 32'(outValid), 32'd1);
        idle(2);
`endif

        // One-slot packer: each slice is a whole word.
        outReady0 = 1'b1;
        inSlice0  = 4'h9;
        inValid0  = 1'b1;
        expQ0.push_back(4'h9);
        expQ0.push_back(4'h3);
        @(posedge clk);
        #1;
        checkOutput("deg first word", 32'(outWord0), 32'h9);
        checkOutput("deg first valid", 32'(outValid0), 32'd1);
        inSlice0 = 4'h3;
        @(posedge clk);
        #1;
        inValid0 = 1'b0;
        checkOutput("deg second word", 32'(outWord0), 32'h3);
        checkOutput("deg second valid", 32'(outValid0), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("deg idle valid", 32'(outValid0), 32'd0);

        idle(3);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        checkOutput("scoreboard0 drained", 32'(expQ0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
